// File: rtl/inference_latency_monitor.sv
// Measures clk cycles from each 01 entry to the following 10 entry on a 2-bit status line,
// keeping last/min/max latency plus frame, timeout and overrun statistics.
module inference_latency_monitor #(
   parameter int unsigned CNT_W   = 32,
   parameter int unsigned TIMEOUT = 1000000,
   parameter int unsigned FCNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        UserInput,
   input  logic              Clear,
   output logic              Busy,
   output logic [CNT_W-1:0]  Latency,
   output logic              Latency_vld,
   output logic [CNT_W-1:0]  MinLatency,
   output logic [CNT_W-1:0]  MaxLatency,
   output logic [FCNT_W-1:0] FrameCount,
   output logic [FCNT_W-1:0] TimeoutCount,
   output logic [FCNT_W-1:0] OverrunCount,
   output logic              Timeout_err
);

   localparam logic [CNT_W-1:0] TimeoutC = CNT_W'(TIMEOUT);

   typedef enum logic {StIdle, StBusy} state_e;

   state_e            state_q, state_d;
   logic [1:0]        s1_q, s1_d, s2_q, s2_d, p_q, p_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  lat_q, lat_d, min_q, min_d, max_q, max_d;
   logic              lat_vld_q, lat_vld_d, terr_q, terr_d;
   logic [FCNT_W-1:0] frame_q, frame_d, tout_q, tout_d, ovr_q, ovr_d;
   logic              start_ev, stop_ev;

   assign start_ev = (s2_q == 2'b01) && (p_q != 2'b01);
   assign stop_ev  = (s2_q == 2'b10) && (p_q != 2'b10);

   always_comb begin
      s1_d      = UserInput;
      s2_d      = s1_q;
      p_d       = s2_q;
      state_d   = state_q;
      cnt_d     = cnt_q;
      lat_d     = lat_q;
      min_d     = min_q;
      max_d     = max_q;
      frame_d   = frame_q;
      tout_d    = tout_q;
      ovr_d     = ovr_q;
      lat_vld_d = 1'b0;
      terr_d    = 1'b0;
      // Clear leaves the synchroniser and the last latency untouched.
      if (Clear) begin
         state_d = StIdle;
         cnt_d   = '0;
         min_d   = '1;
         max_d   = '0;
         frame_d = '0;
         tout_d  = '0;
         ovr_d   = '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start_ev) begin
                  state_d = StBusy;
                  cnt_d   = CNT_W'(1);
               end
            end
            StBusy: begin
               if (stop_ev) begin
                  state_d   = StIdle;
                  lat_d     = cnt_q;
                  lat_vld_d = 1'b1;
                  frame_d   = (&frame_q) ? frame_q : frame_q + FCNT_W'(1);
                  if (cnt_q < min_q) min_d = cnt_q;
                  if (cnt_q > max_q) max_d = cnt_q;
               end else if (start_ev) begin
                  cnt_d = CNT_W'(1);
                  ovr_d = (&ovr_q) ? ovr_q : ovr_q + FCNT_W'(1);
               end else if (cnt_q == TimeoutC) begin
                  state_d = StIdle;
                  terr_d  = 1'b1;
                  tout_d  = (&tout_q) ? tout_q : tout_q + FCNT_W'(1);
               end else begin
                  cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         s1_q      <= 2'b00;
         s2_q      <= 2'b00;
         p_q       <= 2'b00;
         cnt_q     <= '0;
         lat_q     <= '0;
         min_q     <= '1;
         max_q     <= '0;
         frame_q   <= '0;
         tout_q    <= '0;
         ovr_q     <= '0;
         lat_vld_q <= 1'b0;
         terr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         s1_q      <= s1_d;
         s2_q      <= s2_d;
         p_q       <= p_d;
         cnt_q     <= cnt_d;
         lat_q     <= lat_d;
         min_q     <= min_d;
         max_q     <= max_d;
         frame_q   <= frame_d;
         tout_q    <= tout_d;
         ovr_q     <= ovr_d;
         lat_vld_q <= lat_vld_d;
         terr_q    <= terr_d;
      end
   end

   assign Busy         = (state_q == StBusy);
   assign Latency      = lat_q;
   assign Latency_vld  = lat_vld_q;
   assign MinLatency   = min_q;
   assign MaxLatency   = max_q;
   assign FrameCount   = frame_q;
   assign TimeoutCount = tout_q;
   assign OverrunCount = ovr_q;
   assign Timeout_err  = terr_q;

endmodule

// File: tb/tb_inference_latency_monitor.sv
// Directed stimulus for inference_latency_monitor; a scoreboard pairs each expected latency
// or timeout with the DUT pulse that reports it.
module tb_inference_latency_monitor;

   localparam int unsigned TO = 100;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  UserInput = 2'b00;
   logic        Clear = 1'b0;
   logic        Busy, Latency_vld, Timeout_err;
   logic [31:0] Latency, MinLatency, MaxLatency, FrameCount, TimeoutCount, OverrunCount;

   inference_latency_monitor #(
      .CNT_W  (32),
      .TIMEOUT(TO),
      .FCNT_W (32)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .UserInput   (UserInput),
      .Clear       (Clear),
      .Busy        (Busy),
      .Latency     (Latency),
      .Latency_vld (Latency_vld),
      .MinLatency  (MinLatency),
      .MaxLatency  (MaxLatency),
      .FrameCount  (FrameCount),
      .TimeoutCount(TimeoutCount),
      .OverrunCount(OverrunCount),
      .Timeout_err (Timeout_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] lat;
      logic [31:0] mn;
      logic [31:0] mx;
      logic [31:0] frames;
      int          cyc;
   } vld_exp_t;

   typedef struct {
      logic [31:0] tcnt;
      logic [31:0] lat;
      int          cyc;
   } to_exp_t;

   vld_exp_t vq[$];
   to_exp_t  tq[$];
   int       cyc = 0;
   int       n_cmp = 0;
   int       n_err = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                  nm, act, act, exp, exp, cyc);
      end
   endtask

   // Monitor: every output pulse must match the head of its queue.
   always @(negedge clk) begin
      if (!rst) begin
         if (Latency_vld) begin
            if (vq.size() == 0) begin
               chk("unexpected_latency_vld", 64'd1, 64'd0);
            end else begin
               vld_exp_t e;
               e = vq.pop_front();
               chk("latency", Latency, e.lat);
               chk("min_latency", MinLatency, e.mn);
               chk("max_latency", MaxLatency, e.mx);
               chk("frame_count", FrameCount, e.frames);
               chk("latency_vld_cycle", 64'(cyc), 64'(e.cyc));
            end
         end
         if (Timeout_err) begin
            if (tq.size() == 0) begin
               chk("unexpected_timeout_err", 64'd1, 64'd0);
            end else begin
               to_exp_t t;
               t = tq.pop_front();
               chk("timeout_count", TimeoutCount, t.tcnt);
               chk("timeout_latency_kept", Latency, t.lat);
               chk("timeout_err_cycle", 64'(cyc), 64'(t.cyc));
               chk("timeout_busy_low", 64'(Busy), 64'd0);
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // 01 now, 10 exactly n cycles later; the pulse shows 3 cycles after 10 is driven.
   task automatic frame(input int n, input logic [31:0] mn, input logic [31:0] mx,
                        input logic [31:0] fr);
      vld_exp_t e;
      UserInput = 2'b01;
      e.lat     = 32'(n);
      e.mn      = mn;
      e.mx      = mx;
      e.frames  = fr;
      e.cyc     = cyc + n + 3;
      vq.push_back(e);
      step(n);
      UserInput = 2'b10;
   endtask

   task automatic chk_cleared(input string tag, input logic [31:0] lat);
      chk({tag, "_busy"}, 64'(Busy), 64'd0);
      chk({tag, "_latency"}, Latency, lat);
      chk({tag, "_min"}, MinLatency, 32'hFFFF_FFFF);
      chk({tag, "_max"}, MaxLatency, 32'd0);
      chk({tag, "_frames"}, FrameCount, 32'd0);
      chk({tag, "_timeouts"}, TimeoutCount, 32'd0);
      chk({tag, "_overruns"}, OverrunCount, 32'd0);
   endtask

   initial begin
      to_exp_t t;
      step(3);
      chk_cleared("reset", 32'd0);
      chk("reset_vld", 64'(Latency_vld), 64'd0);
      chk("reset_terr", 64'(Timeout_err), 64'd0);
      rst = 1'b0;
      step(3);

      // 1: single 25-cycle measurement
      frame(25, 32'd25, 32'd25, 32'd1);
      step(6);

      // 2: three back-to-back frames after a Clear
      Clear = 1'b1;
      step(1);
      Clear = 1'b0;
      chk("clear_idle_frames", FrameCount, 32'd0);
      chk("clear_idle_latency_kept", Latency, 32'd25);
      step(2);
      frame(10, 32'd10, 32'd10, 32'd1);
      step(3);
      frame(40, 32'd10, 32'd40, 32'd2);
      step(3);
      frame(7, 32'd7, 32'd40, 32'd3);
      step(6);
      chk("t2_latency", Latency, 32'd7);
      chk("t2_frames", FrameCount, 32'd3);

      // 3: hold 01 until the measurement is aborted
      UserInput = 2'b01;
      t.tcnt = 32'd1;
      t.lat  = 32'd7;
      t.cyc  = cyc + 3 + TO;
      tq.push_back(t);
      step(3);
      chk("t3_busy_rose", 64'(Busy), 64'd1);
      step(TO + 5);
      chk("t3_busy_low", 64'(Busy), 64'd0);
      chk("t3_timeouts", TimeoutCount, 32'd1);
      chk("t3_latency_kept", Latency, 32'd7);

      // 4: 01, 11, 01 restarts the count as an overrun
      UserInput = 2'b00;
      step(3);
      UserInput = 2'b01;
      step(4);
      UserInput = 2'b11;
      step(5);
      frame(20, 32'd7, 32'd40, 32'd4);
      step(6);
      chk("t4_overruns", OverrunCount, 32'd1);
      chk("t4_frames", FrameCount, 32'd4);

      // 5: stop code while idle and 00/11 glitches produce nothing
      UserInput = 2'b00;
      step(3);
      UserInput = 2'b10;
      step(3);
      UserInput = 2'b11;
      step(1);
      UserInput = 2'b00;
      step(1);
      UserInput = 2'b11;
      step(2);
      UserInput = 2'b00;
      step(5);
      chk("t5_busy", 64'(Busy), 64'd0);
      chk("t5_frames", FrameCount, 32'd4);
      chk("t5_overruns", OverrunCount, 32'd1);
      chk("t5_timeouts", TimeoutCount, 32'd1);
      chk("t5_latency", Latency, 32'd20);

      // 6a: Clear mid-measurement keeps Latency, then a clean measurement
      UserInput = 2'b01;
      step(10);
      chk("t6_busy_before_clear", 64'(Busy), 64'd1);
      Clear = 1'b1;
      step(1);
      Clear = 1'b0;
      chk_cleared("t6_clear", 32'd20);
      UserInput = 2'b00;
      step(3);
      frame(15, 32'd15, 32'd15, 32'd1);
      step(6);

      // 6b: rst mid-measurement, then a clean measurement
      UserInput = 2'b01;
      step(10);
      chk("t6_busy_before_rst", 64'(Busy), 64'd1);
      rst = 1'b1;
      UserInput = 2'b00;
      step(2);
      rst = 1'b0;
      chk_cleared("t6_rst", 32'd0);
      step(3);
      frame(12, 32'd12, 32'd12, 32'd1);

      for (int i = 0; i < 200 && (vq.size() != 0 || tq.size() != 0); i++) step(1);
      chk("pending_latency_events", 64'(vq.size()), 64'd0);
      chk("pending_timeout_events", 64'(tq.size()), 64'd0);
      step(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
